// File: rtl/uidbufw_arbiter_rr_pkg.sv
// Shared types and helpers for the uidbuf write-channel round-robin arbiter.
package uidbufw_arbiter_rr_pkg;

  localparam int FDMA_SIZE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } arb_state_t;

  // Index width for a channel count. It is never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uidbufw_arbiter_rr_if.sv
// Bundle of NCH uidbuf write masters plus the single merged FDMA write port.
interface uidbufw_arbiter_rr_if
  import uidbufw_arbiter_rr_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int AW  = 21
);
  logic [NCH*AW-1:0]          ch_waddr;
  logic [NCH-1:0]             ch_wareq;
  logic [NCH*FDMA_SIZE_W-1:0] ch_wsize;
  logic [NCH*DW-1:0]          ch_wdata;
  logic [NCH-1:0]             ch_wbusy;
  logic [NCH-1:0]             ch_wvalid;
  logic [AW-1:0]              fdma_waddr;
  logic                       fdma_wareq;
  logic [FDMA_SIZE_W-1:0]     fdma_wsize;
  logic                       fdma_wbusy;
  logic [DW-1:0]              fdma_wdata;
  logic                       fdma_wvalid;

  modport slave (
    input  ch_waddr, ch_wareq, ch_wsize, ch_wdata, fdma_wbusy, fdma_wvalid,
    output ch_wbusy, ch_wvalid, fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata
  );

  modport master (
    output ch_waddr, ch_wareq, ch_wsize, ch_wdata, fdma_wbusy, fdma_wvalid,
    input  ch_wbusy, ch_wvalid, fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata
  );
endinterface

// File: rtl/uidbufw_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from ptr, or lowest index first.
module uidbufw_arbiter_rr_pick
  import uidbufw_arbiter_rr_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int PRIO_MODE = 0,
  parameter int PW        = idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [PW-1:0]  idx
);

  logic          found;
  int            ci;
  logic [PW-1:0] c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    ci    = 0;
    c     = '0;
    if (PRIO_MODE != 0) begin
      for (int i = 0; i < NCH; i++) begin
        if (req[i] && !found) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          idx    = PW'(i);
        end
      end
    end else begin
      // Explicit wrap keeps non-power-of-2 channel counts inside 0..NCH-1.
      for (int off = 0; off < NCH; off++) begin
        ci = int'(ptr) + off;
        if (ci >= NCH) ci = ci - NCH;
        c = PW'(ci);
        if (req[c] && !found) begin
          found  = 1'b1;
          gnt[c] = 1'b1;
          idx    = c;
        end
      end
    end
  end

endmodule

// File: rtl/uidbufw_arbiter_rr.sv
// Merges NCH uidbuf FDMA write masters onto one FDMA write port.
//   state | meaning
//   IDLE  | no grant; arbitrate among ch_wareq
//   REQ   | grant latched, fdma_wareq high, waiting for fdma_wbusy (or timeout)
//   BUSY  | engine running; wait for the fdma_wbusy falling edge
module uidbufw_arbiter_rr
  import uidbufw_arbiter_rr_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 21,
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT        = 1023
) (
  input  logic            ui_clk,
  input  logic            ui_rstn,
  uidbufw_arbiter_rr_if.slave bus,
  output logic [NCH-1:0]  grant,
  output logic            err_timeout
);

  localparam int PW = idx_w(NCH);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int AW = AXI_ADDR_WIDTH;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t             state;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          win;
  logic                   busy_dly;
  logic [TW-1:0]          tmo_cnt;
  logic                   wareq_r;
  logic [AW-1:0]          waddr_r;
  logic [FDMA_SIZE_W-1:0] wsize_r;
  logic [NCH-1:0]         pick_gnt;
  logic [PW-1:0]          pick_idx;
  logic [DW-1:0]          wdata_mux;

  uidbufw_arbiter_rr_pick #(.NCH(NCH), .PRIO_MODE(PRIO_MODE), .PW(PW)) u_pick (
    .req (bus.ch_wareq),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] i);
    if (i == PW'(NCH - 1)) return '0;
    return i + 1'b1;
  endfunction

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state       <= ST_IDLE;
      grant       <= '0;
      ptr         <= '0;
      win         <= '0;
      busy_dly    <= 1'b0;
      tmo_cnt     <= '0;
      wareq_r     <= 1'b0;
      waddr_r     <= '0;
      wsize_r     <= '0;
      err_timeout <= 1'b0;
    end else begin
      busy_dly    <= bus.fdma_wbusy;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|bus.ch_wareq) begin
            state   <= ST_REQ;
            grant   <= pick_gnt;
            win     <= pick_idx;
            wareq_r <= 1'b1;
            waddr_r <= bus.ch_waddr[int'(pick_idx)*AW +: AW];
            wsize_r <= bus.ch_wsize[int'(pick_idx)*FDMA_SIZE_W +: FDMA_SIZE_W];
            tmo_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (bus.fdma_wbusy) begin
            state   <= ST_BUSY;
            wareq_r <= 1'b0;
            tmo_cnt <= '0;
          end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
            state       <= ST_IDLE;
            grant       <= '0;
            wareq_r     <= 1'b0;
            waddr_r     <= '0;
            wsize_r     <= '0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b1;
            if (PRIO_MODE == 0) ptr <= nxt_ptr(win);
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_BUSY: begin
          if (busy_dly && !bus.fdma_wbusy) begin
            state   <= ST_IDLE;
            grant   <= '0;
            waddr_r <= '0;
            wsize_r <= '0;
            if (PRIO_MODE == 0) ptr <= nxt_ptr(win);
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant   <= '0;
          wareq_r <= 1'b0;
        end
      endcase
    end
  end

  // Data path is purely combinational so the engine sees zero added latency.
  always_comb begin
    wdata_mux = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant[k]) wdata_mux = bus.ch_wdata[k*DW +: DW];
    end
  end

  assign bus.fdma_wareq = wareq_r;
  assign bus.fdma_waddr = waddr_r;
  assign bus.fdma_wsize = wsize_r;
  assign bus.fdma_wdata = wdata_mux;
  assign bus.ch_wvalid  = grant & {NCH{bus.fdma_wvalid}};
  assign bus.ch_wbusy   = grant & {NCH{state != ST_IDLE}};

endmodule

// File: tb/tb_uidbufw_arbiter_rr.sv
// Directed bench: RR, fixed-priority and 3-channel builds share one stimulus bus.
module tb_uidbufw_arbiter_rr;

  logic          ui_clk = 1'b0;
  logic          ui_rstn;
  logic [3:0]    req;
  logic [4*21-1:0] addr;
  logic [4*16-1:0] size;
  logic [4*32-1:0] wdata;
  logic          busy, valid;

  logic [3:0]    grant_a, grant_b;
  logic [2:0]    grant_c;
  logic          err_a, err_b, err_c;

  int total = 0;
  int bad   = 0;

  always #5 ui_clk = ~ui_clk;

  uidbufw_arbiter_rr_if #(.NCH(4), .DW(32), .AW(21)) if_a ();
  uidbufw_arbiter_rr_if #(.NCH(4), .DW(32), .AW(21)) if_b ();
  uidbufw_arbiter_rr_if #(.NCH(3), .DW(32), .AW(21)) if_c ();

  assign if_a.ch_waddr = addr;          assign if_b.ch_waddr = addr;
  assign if_a.ch_wareq = req;           assign if_b.ch_wareq = req;
  assign if_a.ch_wsize = size;          assign if_b.ch_wsize = size;
  assign if_a.ch_wdata = wdata;         assign if_b.ch_wdata = wdata;
  assign if_a.fdma_wbusy = busy;        assign if_b.fdma_wbusy = busy;
  assign if_a.fdma_wvalid = valid;      assign if_b.fdma_wvalid = valid;
  assign if_c.ch_waddr = addr[3*21-1:0];
  assign if_c.ch_wareq = req[2:0];
  assign if_c.ch_wsize = size[3*16-1:0];
  assign if_c.ch_wdata = wdata[3*32-1:0];
  assign if_c.fdma_wbusy = busy;
  assign if_c.fdma_wvalid = valid;

  uidbufw_arbiter_rr #(.NCH(4), .PRIO_MODE(0), .TIMEOUT(16)) u_a (
    .ui_clk(ui_clk), .ui_rstn(ui_rstn), .bus(if_a), .grant(grant_a), .err_timeout(err_a));
  uidbufw_arbiter_rr #(.NCH(4), .PRIO_MODE(1), .TIMEOUT(0)) u_b (
    .ui_clk(ui_clk), .ui_rstn(ui_rstn), .bus(if_b), .grant(grant_b), .err_timeout(err_b));
  uidbufw_arbiter_rr #(.NCH(3), .PRIO_MODE(0), .TIMEOUT(1023)) u_c (
    .ui_clk(ui_clk), .ui_rstn(ui_rstn), .bus(if_c), .grant(grant_c), .err_timeout(err_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] gnt_of(input int s);
    case (s)
      0:       return grant_a;
      1:       return grant_b;
      default: return {1'b0, grant_c};
    endcase
  endfunction

  function automatic logic wareq_of(input int s);
    case (s)
      0:       return if_a.fdma_wareq;
      1:       return if_b.fdma_wareq;
      default: return if_c.fdma_wareq;
    endcase
  endfunction

  function automatic logic [3:0] cbusy_of(input int s);
    case (s)
      0:       return if_a.ch_wbusy;
      1:       return if_b.ch_wbusy;
      default: return {1'b0, if_c.ch_wbusy};
    endcase
  endfunction

  task automatic do_reset();
    ui_rstn = 1'b0;
    req = '0; busy = 1'b0; valid = 1'b0;
    repeat (2) @(negedge ui_clk);
    ui_rstn = 1'b1;
    @(negedge ui_clk);
  endtask

  task automatic wait_req(input int s, output int gap);
    gap = 0;
    while (!wareq_of(s) && gap < 100) begin
      @(negedge ui_clk);
      gap++;
    end
    chk("req_seen", 64'(wareq_of(s)), 1);
  endtask

  // Acts as the FDMA engine for one burst of len data beats.
  task automatic serve(input int s, input int len, output logic [3:0] gnt, output int gap);
    wait_req(s, gap);
    gnt = gnt_of(s);
    busy = 1'b1; valid = 1'b1;
    @(negedge ui_clk);
    chk("busy_grant_nz", 64'(gnt_of(s) != 4'b0000), 1);
    chk("busy_grant_hold", gnt_of(s), gnt);
    chk("busy_ch_wbusy", cbusy_of(s), gnt);
    chk("busy_wareq_low", 64'(wareq_of(s)), 0);
    repeat (len - 1) @(negedge ui_clk);
    busy = 1'b0; valid = 1'b0;
    @(negedge ui_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    logic [3:0] exp_rr [5];
    logic [3:0] exp_c  [4];
    int gap, cnt, vcnt;

    for (int k = 0; k < 4; k++) begin
      addr[k*21 +: 21]  = 21'h10000 + 21'(k * 'h111);
      size[k*16 +: 16]  = 16'(16 * (k + 2));
      wdata[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    end
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_c  = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};

    // Reset state
    ui_rstn = 1'b0; req = '0; busy = 1'b0; valid = 1'b1;
    #3;
    chk("rst_grant", grant_a, 0);
    chk("rst_wareq", 64'(if_a.fdma_wareq), 0);
    chk("rst_waddr", if_a.fdma_waddr, 0);
    chk("rst_wsize", if_a.fdma_wsize, 0);
    chk("rst_err", 64'(err_a), 0);
    chk("rst_wvalid", if_a.ch_wvalid, 0);
    do_reset();

    // Single channel ch2, 64-word burst, request dropped after grant
    req = 4'b0100;
    wait_req(0, gap);
    chk("single_grant", grant_a, 4'b0100);
    chk("single_waddr", if_a.fdma_waddr, 21'h10222);
    chk("single_wsize", if_a.fdma_wsize, 64);
    chk("single_wdata", if_a.fdma_wdata, 32'hA000_0002);
    chk("single_ch_wbusy", if_a.ch_wbusy, 4'b0100);
    req = 4'b0000;
    busy = 1'b1; valid = 1'b1; vcnt = 0;
    repeat (64) begin
      @(negedge ui_clk);
      if (if_a.ch_wvalid == 4'b0100) vcnt++;
    end
    chk("single_wvalid_cnt", vcnt, 64);
    chk("single_ch_wbusy_busy", if_a.ch_wbusy, 4'b0100);
    busy = 1'b0; valid = 1'b0;
    @(negedge ui_clk);
    chk("single_idle_grant", grant_a, 0);
    chk("single_idle_ch_wbusy", if_a.ch_wbusy, 0);
    @(negedge ui_clk);
    chk("single_stay_idle", 64'(if_a.fdma_wareq), 0);
    valid = 1'b1;
    #1;
    chk("idle_wvalid_drop", if_a.ch_wvalid, 0);
    valid = 1'b0;

    // Round robin with all four requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(0, 3, g, gap);
      chk("rr_grant", g, exp_rr[i]);
      if (i > 0) chk("rr_gap", gap, 1);
    end

    // Timeout: engine never answers
    do_reset();
    req = 4'b1111;
    wait_req(0, gap);
    chk("tmo_first_grant", grant_a, 4'b0001);
    cnt = 0;
    while (!err_a && cnt < 40) begin
      @(negedge ui_clk);
      cnt++;
    end
    chk("tmo_cycles", cnt, 16);
    chk("tmo_grant_clr", grant_a, 0);
    @(negedge ui_clk);
    chk("tmo_pulse_1cyc", 64'(err_a), 0);
    serve(0, 2, g, gap);
    chk("tmo_next_grant", g, 4'b0010);

    // Reset mid-burst
    do_reset();
    req = 4'b1111;
    serve(0, 2, g, gap);
    chk("rst_mid_first", g, 4'b0001);
    wait_req(0, gap);
    busy = 1'b1; valid = 1'b1;
    repeat (2) @(negedge ui_clk);
    chk("rst_mid_pre", grant_a, 4'b0010);
    ui_rstn = 1'b0;
    #1;
    chk("rst_mid_grant", grant_a, 0);
    chk("rst_mid_ch_wbusy", if_a.ch_wbusy, 0);
    chk("rst_mid_ch_wvalid", if_a.ch_wvalid, 0);
    chk("rst_mid_wareq", 64'(if_a.fdma_wareq), 0);
    chk("rst_mid_waddr", if_a.fdma_waddr, 0);
    chk("rst_mid_wdata", if_a.fdma_wdata, 0);
    @(negedge ui_clk);
    ui_rstn = 1'b1; busy = 1'b0; valid = 1'b0;
    serve(0, 2, g, gap);
    chk("rst_mid_restart", g, 4'b0001);

    // Fixed priority, timeout disabled
    do_reset();
    req = 4'b1001;
    repeat (30) @(negedge ui_clk);
    chk("prio_no_tmo_wareq", 64'(if_b.fdma_wareq), 1);
    chk("prio_no_tmo_err", 64'(err_b), 0);
    chk("prio_no_tmo_grant", grant_b, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      serve(1, 3, g, gap);
      chk("prio_grant", g, 4'b0001);
    end
    req = 4'b1000;
    serve(1, 3, g, gap);
    chk("prio_ch3_alone", g, 4'b1000);

    // Three-channel build wraps 2 -> 0
    do_reset();
    req = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      serve(2, 2, g, gap);
      chk("nch3_grant", g, exp_c[i]);
    end
    chk("nch3_err", 64'(err_c), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
